db_sram_ctrl: RTL
=================

Name: db_sram_ctrl

Overview:
- Data-bus slave that sits directly downstream of CPUCore and replaces the always-ready behavioural memory.
- Accepts one `MEM_ACCESS_R`/`W`/`X` request at a time on the CPU data bus.
- Drives a word-wide synchronous SRAM with a programmable number of wait states.
- Returns a one-cycle completion pulse on db_ready, with read data or an alignment fault.

Parameters:
- ADDR_W, 10, SRAM word-address width (1024 words); SRAM word address is db_addr[ADDR_W+1:2], upper bits ignored (aliasing).
- WAIT_STATES, 1, extra SRAM cycles per access (0..15).

Ports:
- clk  in  1  system clock, rising edge.
- res  in  1  asynchronous, active-low reset.
- db_addr  in  32  byte address from CPU.
- db_dataOut  in  32  write data from CPU.
- db_accessType  in  2  `MEM_ACCESS_R`/`W`/`X` from DataBus.vh; the remaining encoding means no request.
- db_dataIn  out  32  read data to CPU, registered.
- db_ready  out  1  one-cycle completion pulse, registered.
- db_fault  out  1  valid with db_ready: access was misaligned, registered.
- sram_addr  out  ADDR_W  SRAM word address.
- sram_wdata  out  32  SRAM write data.
- sram_rdata  in  32  SRAM read data; valid in any cycle where sram_ce=1 and sram_we=0 for the held address.
- sram_ce  out  1  SRAM chip enable.
- sram_we  out  1  SRAM write enable.

Behaviour:
- Reset (res=0, asynchronous):
  - state=IDLE, db_ready=0, db_fault=0, db_dataIn=0.
  - sram_ce=0, sram_we=0, sram_addr=0, sram_wdata=0, wait counter=0.
  - All take effect immediately, including mid-access; an in-flight access is abandoned and no completion pulse is ever produced for it.
- Requester rules:
  - Holds db_addr, db_dataOut and db_accessType stable from issue until the edge that ends the db_ready cycle.
  - At that edge it presents either the next request or no-request.
- State IDLE:
  - db_ready=0.
  - At a rising edge with a valid type and db_addr[1:0]==0: latch address/data/type, sram_addr<=db_addr[ADDR_W+1:2], sram_wdata<=db_dataOut, sram_ce<=1, sram_we<=(type==W), cnt<=WAIT_STATES, go to ACCESS.
  - At a rising edge with a valid type and db_addr[1:0]!=0: no SRAM activity, db_fault<=1, db_ready<=1, go to RESP; db_dataIn keeps its previous value.
  - No-request encoding: stay in IDLE, outputs unchanged.
- State ACCESS:
  - sram_ce=1; sram_we=1 for every ACCESS cycle of a write.
  - Request inputs are ignored (the latched copy is used).
  - At each edge: if cnt!=0 then cnt<=cnt-1.
  - Else: sram_ce<=0, sram_we<=0, db_fault<=0, db_ready<=1, go to RESP; for R/X also db_dataIn<=sram_rdata.
  - ACCESS therefore lasts WAIT_STATES+1 cycles.
- State RESP:
  - db_ready=1 for exactly one cycle; db_dataIn (R/X) and db_fault are valid.
  - At the next edge: db_ready<=0, db_fault<=0, go to IDLE, inputs ignored.
  - A held request is therefore never accepted twice.
- Latency, aligned access: acceptance edge to db_ready high is WAIT_STATES+2 cycles; back-to-back throughput is one access per WAIT_STATES+3 cycles.
- R and X are identical at the SRAM; writes leave db_dataIn unchanged.
- db_dataIn holds its last read value until the next completed R/X.

Test Plan:
- WAIT_STATES=1; write 0x0000_0009 to 0x4C, then R at 0x4C.
  - Write: sram_we high for exactly 2 cycles at sram_addr=0x13; db_ready pulses 3 cycles after acceptance.
  - Read: db_dataIn=0x0000_0009 with db_ready.
- WAIT_STATES=0; X at 0x0 with SRAM word0=0x2001_0040 -> db_ready pulses 2 cycles after acceptance, db_dataIn=0x2001_0040, db_fault=0.
- R at 0x42 (misaligned) -> sram_ce never asserts; db_ready and db_fault both 1 for one cycle, one cycle after acceptance; db_dataIn unchanged.
- Requester holds the same R request through RESP and IDLE -> exactly one access per acceptance; the next is accepted on the first IDLE edge; the spacing of completion pulses is WAIT_STATES+3 cycles.
- Drop res low during the 2nd ACCESS cycle of a write with WAIT_STATES=3 -> sram_ce, sram_we and db_ready are 0 immediately; after release, state is IDLE and no stale db_ready pulse appears.
- ADDR_W=10; W to 0x1000 then R at 0x0 -> same SRAM word (aliasing), read returns the written data.

Source files
------------

// File: rtl/db_sram_ctrl_if.sv
// CPU data-bus port of db_sram_ctrl: one request at a time, completion pulse
// on db_ready with read data or an alignment fault.
interface db_sram_ctrl_if;
  logic [31:0] db_addr;
  logic [31:0] db_dataOut;
  logic [1:0]  db_accessType;
  logic [31:0] db_dataIn;
  logic        db_ready;
  logic        db_fault;

  modport master (
    output db_addr, db_dataOut, db_accessType,
    input  db_dataIn, db_ready, db_fault
  );

  modport slave (
    input  db_addr, db_dataOut, db_accessType,
    output db_dataIn, db_ready, db_fault
  );
endinterface

// File: rtl/db_sram_ctrl.sv
// Data-bus slave driving a word-wide synchronous SRAM with a fixed number of
// wait states; answers each request with a single-cycle db_ready pulse.
module db_sram_ctrl #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              res,
  db_sram_ctrl_if.slave     db,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata,
  output logic              sram_ce,
  output logic              sram_we
);

  typedef enum logic [1:0] {
    MEM_ACCESS_R    = 2'd0,
    MEM_ACCESS_W    = 2'd1,
    MEM_ACCESS_X    = 2'd2,
    MEM_ACCESS_NONE = 2'd3
  } access_e;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_STATES);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              rd_q, rd_d;
  logic [ADDR_W-1:0] addr_d;
  logic [31:0]       wdata_d;
  logic              ce_d, we_d;
  logic [31:0]       data_q, data_d;
  logic              ready_q, ready_d;
  logic              fault_q, fault_d;

  access_e req_type;
  logic    req_valid;
  logic    req_aligned;
  logic    unused_addr_bits;

  assign req_type    = access_e'(db.db_accessType);
  assign req_valid   = (req_type != MEM_ACCESS_NONE);
  assign req_aligned = (db.db_addr[1:0] == 2'b00);
  // Upper address bits are dropped, so the SRAM aliases across the 4 GB space.
  assign unused_addr_bits = ^db.db_addr[31:ADDR_W+2];

  assign db.db_dataIn = data_q;
  assign db.db_ready  = ready_q;
  assign db.db_fault  = fault_q;

  // NOTE: every signal assigned here gets its hold value first, so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    addr_d  = sram_addr;
    wdata_d = sram_wdata;
    ce_d    = sram_ce;
    we_d    = sram_we;
    data_d  = data_q;
    ready_d = ready_q;
    fault_d = fault_q;

    unique case (state_q)
      IDLE: begin
        ready_d = 1'b0;
        if (req_valid) begin
          if (req_aligned) begin
            addr_d  = db.db_addr[ADDR_W+1:2];
            wdata_d = db.db_dataOut;
            rd_d    = (req_type != MEM_ACCESS_W);
            ce_d    = 1'b1;
            we_d    = (req_type == MEM_ACCESS_W);
            cnt_d   = CNT_INIT;
            state_d = ACCESS;
          end else begin
            fault_d = 1'b1;
            ready_d = 1'b1;
            state_d = RESP;
          end
        end
      end

      ACCESS: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          ce_d    = 1'b0;
          we_d    = 1'b0;
          fault_d = 1'b0;
          ready_d = 1'b1;
          if (rd_q) data_d = sram_rdata;
          state_d = RESP;
        end
      end

      RESP: begin
        // Inputs are ignored here, so a request held through RESP is only
        // taken again on the following IDLE edge.
        ready_d = 1'b0;
        fault_d = 1'b0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      rd_q       <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      sram_ce    <= 1'b0;
      sram_we    <= 1'b0;
      data_q     <= '0;
      ready_q    <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_q       <= rd_d;
      sram_addr  <= addr_d;
      sram_wdata <= wdata_d;
      sram_ce    <= ce_d;
      sram_we    <= we_d;
      data_q     <= data_d;
      ready_q    <= ready_d;
      fault_q    <= fault_d;
    end
  end

endmodule
